pipe_hazard_regs: RTL
=====================

Name: pipe_hazard_regs

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage MIPS core.
- Holds all four pipeline register banks with per-stage valid bits, and adds behaviour the current pipeline lacks: load-use stall, taken-branch flush (branch resolves in MEM), external freeze, EX-stage forwarding selects, and saturating stall/flush counters.
- Sits in the core top between the stage modules; the stages keep their own datapath logic.

Parameters:
IFID_W, 44, IF/ID bank width
IDEX_W, 127, ID/EX bank width
EXMEM_W, 87, EX/MEM bank width
MEMWB_W, 71, MEM/WB bank width
REG_AW, 5, register-address width
CNT_W, 16, performance-counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
ifid_d  in  IFID_W  next IF/ID contents (IR, NPC)
idex_d  in  IDEX_W  next ID/EX contents
exmem_d  in  EXMEM_W  next EX/MEM contents
memwb_d  in  MEMWB_W  next MEM/WB contents
id_rs, id_rt  in  REG_AW  source regs of instruction in ID
id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
idex_rs, idex_rt, idex_rd  in  REG_AW  fields of instruction in EX
idex_memread  in  1  EX instruction is a load
exmem_rd, memwb_rd  in  REG_AW  destinations in MEM / WB
exmem_regwrite, memwb_regwrite  in  1  MEM / WB instruction writes a register
branch_taken  in  1  MEM stage resolves a taken branch (PCSrc)
ext_stall  in  1  freeze entire pipeline (e.g. memory wait)
ifid_q, idex_q, exmem_q, memwb_q  out  *_W  registered banks
ifid_v, idex_v, exmem_v, memwb_v  out  1  stage valid bits
pc_en  out  1  PC update enable for IF stage
fwd_a, fwd_b  out  2  ALU operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
load_use  out  1  load-use hazard detected this cycle
stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: one clock, synchronous, active-high (clk; rst). While rst is high at an edge, all *_q become 0, all valid bits 0, and counters 0. pc_en = 0 while rst is high. Reset mid-stall or mid-flush overrides everything.
- Hazard term (combinational): load_use = ifid_v & idex_v & idex_memread & (idex_rd != 0) & ((id_uses_rs & id_rs == idex_rd) | (id_uses_rt & id_rt == idex_rd)).
- flush = branch_taken & exmem_v.
- Edge priority: rst > ext_stall > flush > load_use > normal.
  - ext_stall: all banks and valid bits hold. Counters hold. pc_en = 0.
  - flush: ifid, idex and exmem are loaded with 0 and their valid bits cleared (3 wrong-path instructions squashed). memwb loads memwb_d with memwb_v <= exmem_v. pc_en = 1, so IF takes the branch target. flush_cnt++. A load_use in the same cycle is ignored and stall_cnt does not increment.
  - load_use: ifid holds. idex gets a bubble (0, idex_v = 0). exmem and memwb advance. pc_en = 0. stall_cnt++.
  - normal: every bank loads its *_d. ifid_v <= 1, idex_v <= ifid_v, exmem_v <= idex_v, memwb_v <= exmem_v. pc_en = 1.
- Every invalidated bank holds all-zero data, so its embedded control bits are inert.
- Latency: 1 cycle per bank. First valid instruction reaches memwb_v 4 edges after reset release.
- Forwarding (combinational, evaluated per operand, shown for fwd_a using idex_rs; fwd_b is the same with idex_rt):
  - 00 if !idex_v.
  - Otherwise 10 if exmem_v & exmem_regwrite & exmem_rd != 0 & exmem_rd == idex_rs.
  - Otherwise 01 if memwb_v & memwb_regwrite & memwb_rd != 0 & memwb_rd == idex_rs.
  - Otherwise 00. EX/MEM wins when both stages match.
- Counters saturate at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset then free-run with ifid_d = 0x00A_12345678: ifid_v=1 after edge 1. memwb_v=1 after edge 4. fwd_a = fwd_b = 00. Counters 0.
- Load-use: idex_v=1, idex_memread=1, idex_rd=5; id_rs=5, id_uses_rs=1 → load_use=1, pc_en=0. Next edge: ifid_q unchanged, idex_v=0, idex_q=0, stall_cnt=1.
- Same-reg $0: idex_rd=0, id_rs=0 → load_use=0, no stall.
- Forwarding priority: idex_rs=3, exmem_rd=3, memwb_rd=3, both regwrite=1 → fwd_a=10. Drop exmem_regwrite → 01. idex_rt=7 with no match → fwd_b=00.
- Branch flush with simultaneous load_use: exmem_v=1, branch_taken=1, load_use=1 → after edge ifid_v=idex_v=exmem_v=0 and memwb_v=1. flush_cnt=1, stall_cnt unchanged.
- ext_stall=1 held 3 cycles with branch_taken=1: all banks, valid bits and counters frozen; pc_en=0. On release, flush occurs on the next edge. Then assert rst during a load_use stall: all outputs 0 after that edge. With CNT_W=2, 5 stalls → stall_cnt=3.

Source files
------------

// File: rtl/pipe_hazard_regs.sv
// Pipeline register banks IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage valid bits and
// hazard handling: load-use stall, taken-branch flush (branch resolved in MEM), external
// freeze, EX-stage forwarding selects and saturating stall/flush event counters.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   ifid_d/idex_d/exmem_d/memwb_d next contents of each bank
//   id_rs, id_rt, id_uses_rs/rt   source registers of the instruction in ID
//   idex_rs/rt/rd, idex_memread   fields of the instruction in EX
//   exmem_rd/regwrite             destination of the instruction in MEM
//   memwb_rd/regwrite             destination of the instruction in WB
//   branch_taken                  MEM stage resolves a taken branch
//   ext_stall                     freeze the entire pipeline
//   ifid_q/idex_q/exmem_q/memwb_q registered banks
//   ifid_v/idex_v/exmem_v/memwb_v stage valid bits
//   pc_en                         PC update enable for IF
//   fwd_a, fwd_b                  ALU operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   load_use                      load-use hazard detected this cycle
//   stall_cnt, flush_cnt          saturating event counters
module pipe_hazard_regs #(
  parameter int unsigned IFID_W  = 44,
  parameter int unsigned IDEX_W  = 127,
  parameter int unsigned EXMEM_W = 87,
  parameter int unsigned MEMWB_W = 71,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IFID_W-1:0]  ifid_d,
  input  logic [IDEX_W-1:0]  idex_d,
  input  logic [EXMEM_W-1:0] exmem_d,
  input  logic [MEMWB_W-1:0] memwb_d,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [REG_AW-1:0]  idex_rs,
  input  logic [REG_AW-1:0]  idex_rt,
  input  logic [REG_AW-1:0]  idex_rd,
  input  logic               idex_memread,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic [REG_AW-1:0]  memwb_rd,
  input  logic               exmem_regwrite,
  input  logic               memwb_regwrite,
  input  logic               branch_taken,
  input  logic               ext_stall,
  output logic [IFID_W-1:0]  ifid_q,
  output logic [IDEX_W-1:0]  idex_q,
  output logic [EXMEM_W-1:0] exmem_q,
  output logic [MEMWB_W-1:0] memwb_q,
  output logic               ifid_v,
  output logic               idex_v,
  output logic               exmem_v,
  output logic               memwb_v,
  output logic               pc_en,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               load_use,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic flush;
  logic stall_sat;
  logic flush_sat;

  assign load_use = ifid_v & idex_v & idex_memread & (idex_rd != '0) &
                    ((id_uses_rs & (id_rs == idex_rd)) | (id_uses_rt & (id_rt == idex_rd)));

  assign flush     = branch_taken & exmem_v;
  assign stall_sat = (stall_cnt == {CNT_W{1'b1}});
  assign flush_sat = (flush_cnt == {CNT_W{1'b1}});

  // PC enable follows the same priority as the bank update below.
  always_comb begin
    pc_en = 1'b1;
    if (rst || ext_stall) begin
      pc_en = 1'b0;
    end else if (flush) begin
      pc_en = 1'b1;
    end else if (load_use) begin
      pc_en = 1'b0;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              ex_v,
                                         input logic              mem_v,
                                         input logic              mem_wr,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              wb_v,
                                         input logic              wb_wr,
                                         input logic [REG_AW-1:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    // EX/MEM is checked first: it holds the younger result.
    if (ex_v) begin
      if (mem_v && mem_wr && (mem_rd != '0) && (mem_rd == src)) begin
        sel = 2'b10;
      end else if (wb_v && wb_wr && (wb_rd != '0) && (wb_rd == src)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(idex_rs, idex_v, exmem_v, exmem_regwrite, exmem_rd,
                    memwb_v, memwb_regwrite, memwb_rd);
    fwd_b = fwd_sel(idex_rt, idex_v, exmem_v, exmem_regwrite, exmem_rd,
                    memwb_v, memwb_regwrite, memwb_rd);
  end

  // A bank whose valid bit goes low is loaded with zeros so its control fields are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q    <= '0;
      idex_q    <= '0;
      exmem_q   <= '0;
      memwb_q   <= '0;
      ifid_v    <= 1'b0;
      idex_v    <= 1'b0;
      exmem_v   <= 1'b0;
      memwb_v   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (ext_stall) begin
      // Full freeze: nothing moves.
    end else if (flush) begin
      ifid_q    <= '0;
      idex_q    <= '0;
      exmem_q   <= '0;
      ifid_v    <= 1'b0;
      idex_v    <= 1'b0;
      exmem_v   <= 1'b0;
      memwb_q   <= memwb_d;
      memwb_v   <= exmem_v;
      flush_cnt <= flush_sat ? flush_cnt : flush_cnt + 1'b1;
    end else if (load_use) begin
      // IF/ID holds; a bubble enters EX while older instructions drain.
      idex_q    <= '0;
      idex_v    <= 1'b0;
      exmem_q   <= idex_v ? exmem_d : '0;
      exmem_v   <= idex_v;
      memwb_q   <= exmem_v ? memwb_d : '0;
      memwb_v   <= exmem_v;
      stall_cnt <= stall_sat ? stall_cnt : stall_cnt + 1'b1;
    end else begin
      ifid_q    <= ifid_d;
      ifid_v    <= 1'b1;
      idex_q    <= ifid_v ? idex_d : '0;
      idex_v    <= ifid_v;
      exmem_q   <= idex_v ? exmem_d : '0;
      exmem_v   <= idex_v;
      memwb_q   <= exmem_v ? memwb_d : '0;
      memwb_v   <= exmem_v;
    end
  end

endmodule
